// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
//   Word-stream bundle between an LFSR source (master) and the sequence
//   checker (slave). Clock and reset are kept off the bundle.
//   rnd / rnd_valid : observed 32-bit LFSR state word and its qualifier
//   clr_cnt         : synchronous clear of the two statistics counters
//   locked, err, stuck, err_count, match_count : checker status (registered)
interface lfsr_checker_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      rnd;
  logic             rnd_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic             stuck;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] match_count;

  modport master (
    output rnd, rnd_valid, clr_cnt,
    input  locked, err, stuck, err_count, match_count
  );

  modport slave (
    input  rnd, rnd_valid, clr_cnt,
    output locked, err, stuck, err_count, match_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Self-synchronising checker for a 32-bit Fibonacci-style LFSR word stream.
//   The first nonzero word seeds an internal predictor; LOCK_COUNT further
//   correct successors declare lock. Once locked the predictor free-runs
//   (flywheel) so single corrupted words are flagged without disturbing the
//   following comparisons; UNLOCK_ERRS consecutive misses drop back to hunt.
//
//   Ports
//     clk    : single clock, rising edge
//     reset  : synchronous, active-high
//     bus    : lfsr_checker_if.slave (rnd, rnd_valid, clr_cnt in;
//              locked, err, stuck, err_count, match_count out)
//
//   Parameters
//     LOCK_COUNT  : correct predictions needed to lock (>=1)
//     UNLOCK_ERRS : consecutive misses in lock that drop lock (>=1)
//     CNT_W       : width of the saturating statistics counters; must match
//                   the CNT_W of the connected interface
module lfsr_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);

  // Counters only ever hold 0..N-1; reaching N is detected one step early.
  localparam int RUN_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
  localparam int ERR_W = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Successor: shift right, feedback from taps 31,21,1,0 into the MSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {s[31] ^ s[21] ^ s[1] ^ s[0], s[31:1]};
  endfunction

  state_t           r_state;
  logic [31:0]      r_pred;
  logic [RUN_W-1:0] r_run;
  logic [ERR_W-1:0] r_cerr;
  logic             r_locked;
  logic             r_err;
  logic             r_stuck;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_match_count;

  logic [31:0]      w_next_rnd;
  logic [31:0]      w_next_pred;
  logic             w_zero;
  logic             w_hit;
  logic             w_run_done;
  logic             w_unlock;
  logic [CNT_W-1:0] w_err_count_inc;
  logic [CNT_W-1:0] w_match_count_inc;

  assign w_next_rnd  = lfsr_next(bus.rnd);
  assign w_next_pred = lfsr_next(r_pred);
  assign w_zero      = (bus.rnd == 32'd0);
  assign w_hit       = (bus.rnd == r_pred);
  assign w_run_done  = (r_run  == RUN_LAST);
  assign w_unlock    = (r_cerr == ERR_LAST);

  // Saturating increments: hold at all-ones instead of wrapping.
  assign w_err_count_inc   = (&r_err_count)   ? r_err_count
                                              : r_err_count + 1'b1;
  assign w_match_count_inc = (&r_match_count) ? r_match_count
                                              : r_match_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_pred        <= 32'd0;
      r_run         <= '0;
      r_cerr        <= '0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_stuck       <= 1'b0;
      r_err_count   <= '0;
      r_match_count <= '0;
    end else begin
      // err is a single-cycle pulse per bad word.
      r_err <= 1'b0;

      if (bus.rnd_valid) begin
        r_stuck <= w_zero;

        case (r_state)
          ST_HUNT: begin
            // All-zero is the LFSR lock-up state and cannot seed a sequence.
            if (!w_zero) begin
              r_pred  <= w_next_rnd;
              r_run   <= '0;
              r_state <= ST_SYNC;
            end
          end

          ST_SYNC: begin
            if (w_zero) begin
              r_state <= ST_HUNT;
            end else if (w_hit) begin
              r_pred <= w_next_rnd;
              if (w_run_done) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_cerr   <= '0;
                r_run    <= '0;
              end else begin
                r_run <= r_run + 1'b1;
              end
            end else begin
              // Not yet trusted: follow the input instead of flagging it.
              r_pred <= w_next_rnd;
              r_run  <= '0;
            end
          end

          ST_LOCKED: begin
            // Flywheel: the predictor never takes input once locked, so one
            // corrupted word costs exactly one err pulse.
            r_pred <= w_next_pred;
            if (w_hit) begin
              r_match_count <= w_match_count_inc;
              r_cerr        <= '0;
            end else begin
              r_err       <= 1'b1;
              r_err_count <= w_err_count_inc;
              if (w_unlock) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_cerr   <= '0;
              end else begin
                r_cerr <= r_cerr + 1'b1;
              end
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Placed last so a clear beats a same-edge increment.
      if (bus.clr_cnt) begin
        r_err_count   <= '0;
        r_match_count <= '0;
      end
    end
  end

  assign bus.locked      = r_locked;
  assign bus.err         = r_err;
  assign bus.stuck       = r_stuck;
  assign bus.err_count   = r_err_count;
  assign bus.match_count = r_match_count;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Self-synchronising sequence checker for the 32-bit LFSR random-number stream produced by the design's RNG. It sits on the receiving side of an `rnd` word stream and seeds its own predictor from the first observed word. It then verifies that every following word equals the LFSR successor of the previous one, and reports lock status, error pulses and saturating match/error counts. Its uses are in-system RNG health monitoring and a hardware reference checker for benches.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct predictions required to declare lock (≥1).
- `UNLOCK_ERRS`, default 4: consecutive mispredictions in LOCKED that drop lock (≥1).
- `CNT_W`, default 32: width of `err_count` and `match_count`.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rnd`  in  32  observed LFSR state word.
- `rnd_valid`  in  1  `rnd` is sampled on this edge when high.
- `clr_cnt`  in  1  synchronous clear of `err_count` and `match_count` only.
- `locked`  out  1  checker is in LOCKED.
- `err`  out  1  one-cycle pulse for each mismatching word while LOCKED.
- `stuck`  out  1  the most recent valid word was all-zero (LFSR lock-up state).
- `err_count`  out  CNT_W  saturating count of mismatches while LOCKED.
- `match_count`  out  CNT_W  saturating count of matching words while LOCKED.

## Operation
- Successor function: `next(s) = {s[31]^s[21]^s[1]^s[0], s[31:1]}`.
- Internal registers: 32-bit predictor `pred`, match run counter, consecutive-error counter, and a state register with states HUNT, SYNC and LOCKED.
- Cycles with `rnd_valid` low hold all state, counters and `pred`. On these cycles `err` is 0.
- `stuck` updates on every valid word: 1 if `rnd==0`, otherwise 0.
- HUNT:
  - If a valid word equals 0, stay in HUNT.
  - If a valid word is nonzero, set `pred<=next(rnd)`, clear the run counter, and go to SYNC.
- SYNC:
  - A valid word equal to 0 returns to HUNT.
  - If `rnd==pred`, increment the run counter and set `pred<=next(rnd)`. If the run reaches `LOCK_COUNT`, go to LOCKED and clear the consecutive-error counter.
  - If `rnd!=pred`, reseed: set `pred<=next(rnd)`, clear the run counter, and stay in SYNC.
- LOCKED (flywheel: `pred` is never reseeded from input):
  - Match: increment `match_count` (saturating), clear the consecutive-error counter, and set `pred<=next(pred)`.
  - Mismatch, including a zero word: assert `err`, increment `err_count` (saturating), increment the consecutive-error counter, and set `pred<=next(pred)`.
  - If the consecutive-error counter reaches `UNLOCK_ERRS`, go to HUNT.
- Counters stick at all-ones and do not wrap.
- When `clr_cnt` and an increment happen on the same edge, the clear wins and the counter becomes 0.
- `clr_cnt` does not affect state, `pred` or `locked`.

## Timing
- All outputs are registered.
- Reset values: `locked=0`, `err=0`, `stuck=0`, `err_count=0`, `match_count=0`, state HUNT, `pred=0`.
- Reset applied mid-operation has the same effect as reset at power-up. It takes priority over `rnd_valid` and `clr_cnt`.
- Lock latency: `locked` rises on the edge that samples the (`LOCK_COUNT`+1)-th consecutive valid word of a correct sequence. The first word seeds the predictor; the remaining `LOCK_COUNT` words are verified.
- `err` is high for exactly the one cycle following the edge that sampled the bad word. `err_count` updates on that same edge.
- `locked` falls on the edge that samples the `UNLOCK_ERRS`-th consecutive bad word. That word still pulses `err` and counts in `err_count`.
- After lock is lost, the next valid nonzero word reseeds, exactly as in HUNT.
- Throughput: one word per clock. Back-to-back valid words are fully supported.

## Test plan
- Lock-in:
  - Stimulus: reset, then valid words 0xAAAA_AAAA, 0xD555_5555, and the next 3 successors, all back-to-back.
  - Required response: `locked=1` after the 5th word, `err_count=0`, and `match_count` increments on each subsequent correct word.
- Single error under lock:
  - Stimulus: while locked, replace one word with its value XOR 0x1, then continue the correct sequence.
  - Required response: one `err` pulse, `err_count=1`, `locked` stays 1, and the following words match (flywheel).
- Loss of lock:
  - Stimulus: 4 consecutive wrong words, then a fresh sequence seeded from 0x0000_FFFF.
  - Required response: `err_count` +4 and `locked` drops on the 4th wrong word. After 1+4 correct words of the new sequence, `locked=1` again.
- Stuck state:
  - Stimulus: after reset, feed 0x0000_0000 three times.
  - Required response: `stuck=1`, state stays HUNT, `locked=0`, no `err`. A following word of 0xFFFF_FFFE clears `stuck` and enters SYNC.
- Valid gaps and sync reseed:
  - Stimulus: a correct sequence with `rnd_valid` low for random 0–3 cycles between words, plus one wrong word during SYNC.
  - Required response: the gaps do not affect lock latency (counted in valid words). The wrong word in SYNC causes a reseed with no `err` pulse.
- Counters:
  - Stimulus: set `CNT_W`=4, force 20 errors while locked, then pulse `clr_cnt`; separately apply `reset` while locked.
  - Required response: `err_count` saturates at 15 and clears to 0 on `clr_cnt` with `locked` unchanged. On `reset`, all outputs return to 0 on the next edge.
